// File: rtl/icache_refill_if.sv
// Bundle of the cache-side and memory-side signals of the instruction-cache refill engine.
// master: the refill engine; slave: the cache/memory environment around it.
interface icache_refill_if;
  logic [31:0]  ic_addr_i;
  logic         ic_valid_req_i;
  logic         ic_flush_i;
  logic         ic_ready_o;
  logic [127:0] ic_data_o;
  logic         ic_err_o;
  logic         mem_req_o;
  logic [31:0]  mem_addr_o;
  logic         mem_gnt_i;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;

  modport master (
    input  ic_addr_i, ic_valid_req_i, ic_flush_i,
    output ic_ready_o, ic_data_o, ic_err_o,
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    output ic_addr_i, ic_valid_req_i, ic_flush_i,
    input  ic_ready_o, ic_data_o, ic_err_o,
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/icache_refill.sv
// Instruction-cache line refill: issues four word reads for a 16-byte line, assembles the
// returned beats and delivers the line, with flush (drop) and timeout handling.
module icache_refill #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  icache_refill_if.master bus
);

  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [31:0]        base_q, base_d;
  logic [2:0]         issued_q, issued_d;
  logic [2:0]         received_q, received_d;
  logic               drop_q, drop_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [3:0][31:0]   line_q, line_d;
  logic [127:0]       data_q, data_d;
  logic               err_q, err_d;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    issued_d   = issued_q;
    received_d = received_q;
    drop_d     = drop_q;
    tcnt_d     = tcnt_q;
    line_d     = line_q;
    data_d     = data_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (bus.ic_valid_req_i) begin
          base_d     = bus.ic_addr_i & ~32'hF;
          issued_d   = '0;
          received_d = '0;
          drop_d     = 1'b0;
          tcnt_d     = '0;
          err_d      = 1'b0;
          state_d    = REQ;
        end
      end

      REQ, WAIT: begin
        if (state_q == REQ && bus.mem_gnt_i) issued_d = issued_q + 3'd1;
        if (bus.mem_rvalid_i) begin
          line_d[received_q[1:0]] = bus.mem_rdata_i;
          received_d              = received_q + 3'd1;
        end
        if (bus.ic_flush_i) drop_d = 1'b1;
        if (bus.mem_gnt_i || bus.mem_rvalid_i) tcnt_d = '0;
        else                                    tcnt_d = tcnt_q + 1'b1;

        // Drop must win over completion so a flush coinciding with the last beat suppresses delivery.
        if (drop_d && received_d == issued_d) begin
          state_d = IDLE;
        end else if (!drop_d && received_d == 3'd4) begin
          state_d = RESP;
          data_d  = line_d;
        end else if (tcnt_d == TW'(TIMEOUT_CYC)) begin
          if (drop_d) begin
            state_d = IDLE;
          end else begin
            state_d = RESP;
            err_d   = 1'b1;
            data_d  = line_d;
          end
        end else if (state_q == REQ && (issued_d == 3'd4 || drop_d)) begin
          state_d = WAIT;
        end
      end

      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      issued_q   <= '0;
      received_q <= '0;
      drop_q     <= 1'b0;
      tcnt_q     <= '0;
      line_q     <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      drop_q     <= drop_d;
      tcnt_q     <= tcnt_d;
      line_q     <= line_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  assign bus.ic_ready_o = (state_q == RESP);
  assign bus.ic_err_o   = (state_q == RESP) && err_q;
  assign bus.ic_data_o  = data_q;
  assign bus.mem_req_o  = (state_q == REQ);
  assign bus.mem_addr_o = base_q + {27'd0, issued_q, 2'b00};

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a cycle table for the basic and stalled-grant refills,
// plus hand-written flush, timeout, coincident-flush and async-reset sequences.
module tb_icache_refill;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_refill_if bus_if();

  icache_refill #(.TIMEOUT_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.master)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         vreq;
    logic [31:0]  addr;
    logic         flush;
    logic         gnt;
    logic         rvalid;
    logic [31:0]  rdata;
    logic         exp_req;
    logic [31:0]  exp_addr;
    logic         exp_ready;
    logic         exp_err;
    logic         chk_data;
    logic [127:0] exp_data;
  } vec_t;

  localparam logic [127:0] D1 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] D2 = 128'h00000088_00000077_00000066_00000055;

  vec_t tbl [20];

  function automatic vec_t mk(input logic vreq, input logic [31:0] addr, input logic flush,
                              input logic gnt, input logic rvalid, input logic [31:0] rdata,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_ready, input logic exp_err,
                              input logic chk_data, input logic [127:0] exp_data);
    vec_t v;
    v.vreq = vreq; v.addr = addr; v.flush = flush; v.gnt = gnt; v.rvalid = rvalid;
    v.rdata = rdata; v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_ready = exp_ready;
    v.exp_err = exp_err; v.chk_data = chk_data; v.exp_data = exp_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.ic_valid_req_i = 1'b0;
    bus_if.ic_addr_i      = '0;
    bus_if.ic_flush_i     = 1'b0;
    bus_if.mem_gnt_i      = 1'b0;
    bus_if.mem_rvalid_i   = 1'b0;
    bus_if.mem_rdata_i    = '0;
  endtask

  // Zero-wait refill; flush_k selects a cycle (1..7) in which ic_flush_i is raised, 0 for none.
  task automatic run_zero_wait(input string tag, input logic [31:0] addr,
                               input logic [127:0] line, input int flush_k);
    logic [31:0] base;
    base = addr & ~32'hF;
    @(negedge clk);
    bus_if.ic_valid_req_i = 1'b1;
    bus_if.ic_addr_i      = addr;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus_if.ic_valid_req_i = 1'b0;
      check($sformatf("%s c%0d req", tag, k), bus_if.mem_req_o, (k <= 4));
      if (k <= 4)
        check($sformatf("%s c%0d addr", tag, k), bus_if.mem_addr_o, base + 32'(4 * (k - 1)));
      check($sformatf("%s c%0d ready", tag, k), bus_if.ic_ready_o, (k == 6 && flush_k == 0));
      if (k == 6 && flush_k == 0) begin
        check($sformatf("%s data", tag), bus_if.ic_data_o, line);
        check($sformatf("%s err", tag), bus_if.ic_err_o, 1'b0);
      end
      bus_if.mem_gnt_i    = (k <= 4);
      bus_if.mem_rvalid_i = (k >= 2 && k <= 5);
      if (k >= 2 && k <= 5) bus_if.mem_rdata_i = line[(k - 2) * 32 +: 32];
      else                  bus_if.mem_rdata_i = '0;
      bus_if.ic_flush_i   = (k == flush_k);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    tbl[0]  = mk(1, 32'h1234, 0, 0, 0, 0,     0, 0,         0, 0, 0, 0);
    tbl[1]  = mk(0, 0,        0, 1, 0, 0,     1, 32'h1230,  0, 0, 0, 0);
    tbl[2]  = mk(0, 0,        0, 1, 1, 32'h11, 1, 32'h1234, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0,        0, 1, 1, 32'h22, 1, 32'h1238, 0, 0, 0, 0);
    tbl[4]  = mk(0, 0,        0, 1, 1, 32'h33, 1, 32'h123C, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0,        0, 0, 1, 32'h44, 0, 0,        0, 0, 0, 0);
    tbl[6]  = mk(0, 0,        1, 0, 0, 0,     0, 0,         1, 0, 1, D1);
    tbl[7]  = mk(0, 0,        0, 0, 1, 32'hDEAD, 0, 0,      0, 0, 1, D1);
    tbl[8]  = mk(1, 32'h1234, 0, 0, 0, 0,     0, 0,         0, 0, 1, D1);
    tbl[9]  = mk(0, 0,        0, 1, 0, 0,     1, 32'h1230,  0, 0, 0, 0);
    tbl[10] = mk(0, 0,        0, 1, 1, 32'h55, 1, 32'h1234, 0, 0, 0, 0);
    tbl[11] = mk(0, 0,        0, 0, 1, 32'h66, 1, 32'h1238, 0, 0, 0, 0);
    tbl[12] = mk(0, 0,        0, 0, 0, 0,     1, 32'h1238,  0, 0, 0, 0);
    tbl[13] = mk(0, 0,        0, 0, 0, 0,     1, 32'h1238,  0, 0, 0, 0);
    tbl[14] = mk(0, 0,        0, 1, 0, 0,     1, 32'h1238,  0, 0, 0, 0);
    tbl[15] = mk(0, 0,        0, 1, 1, 32'h77, 1, 32'h123C, 0, 0, 0, 0);
    tbl[16] = mk(1, 32'h9990, 0, 0, 1, 32'h88, 0, 0,        0, 0, 0, 0);
    tbl[17] = mk(1, 32'hA000, 0, 0, 0, 0,     0, 0,         1, 0, 1, D2);
    tbl[18] = mk(0, 0,        0, 0, 0, 0,     0, 0,         0, 0, 1, D2);
    tbl[19] = mk(0, 0,        0, 0, 0, 0,     0, 0,         0, 0, 0, 0);

    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("reset ready", bus_if.ic_ready_o, 1'b0);
    check("reset err",   bus_if.ic_err_o,   1'b0);
    check("reset req",   bus_if.mem_req_o,  1'b0);
    check("reset addr",  bus_if.mem_addr_o, 32'h0);
    check("reset data",  bus_if.ic_data_o,  128'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d ready", i), bus_if.ic_ready_o, tbl[i].exp_ready);
      check($sformatf("vec%0d err", i),   bus_if.ic_err_o,   tbl[i].exp_err);
      check($sformatf("vec%0d req", i),   bus_if.mem_req_o,  tbl[i].exp_req);
      if (tbl[i].exp_req)  check($sformatf("vec%0d addr", i), bus_if.mem_addr_o, tbl[i].exp_addr);
      if (tbl[i].chk_data) check($sformatf("vec%0d data", i), bus_if.ic_data_o,  tbl[i].exp_data);
      bus_if.ic_valid_req_i = tbl[i].vreq;
      bus_if.ic_addr_i      = tbl[i].addr;
      bus_if.ic_flush_i     = tbl[i].flush;
      bus_if.mem_gnt_i      = tbl[i].gnt;
      bus_if.mem_rvalid_i   = tbl[i].rvalid;
      bus_if.mem_rdata_i    = tbl[i].rdata;
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();

    // Flush after the second grant: third address must never be granted or re-requested.
    bus_if.ic_valid_req_i = 1'b1;
    bus_if.ic_addr_i      = 32'h2000;
    @(posedge clk);
    @(negedge clk);
    bus_if.ic_valid_req_i = 1'b0;
    check("flush c1 addr", bus_if.mem_addr_o, 32'h2000);
    bus_if.mem_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush c2 addr", bus_if.mem_addr_o, 32'h2004);
    @(posedge clk);
    @(negedge clk);
    check("flush c3 req", bus_if.mem_req_o, 1'b1);
    check("flush c3 addr", bus_if.mem_addr_o, 32'h2008);
    bus_if.mem_gnt_i  = 1'b0;
    bus_if.ic_flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush c4 req", bus_if.mem_req_o, 1'b0);
    bus_if.ic_flush_i   = 1'b0;
    bus_if.mem_gnt_i    = 1'b1;
    bus_if.mem_rvalid_i = 1'b1;
    bus_if.mem_rdata_i  = 32'hAAAA;
    @(posedge clk);
    @(negedge clk);
    check("flush c5 req", bus_if.mem_req_o, 1'b0);
    check("flush c5 ready", bus_if.ic_ready_o, 1'b0);
    bus_if.mem_gnt_i   = 1'b0;
    bus_if.mem_rdata_i = 32'hBBBB;
    @(posedge clk);
    @(negedge clk);
    check("flush c6 ready", bus_if.ic_ready_o, 1'b0);
    check("flush c6 req", bus_if.mem_req_o, 1'b0);
    idle_inputs();
    run_zero_wait("after_flush", 32'h2004, 128'hD4_000000D3_000000D2_000000D1, 0);

    // Flush coinciding with the final beat: no delivery, back to IDLE.
    run_zero_wait("flush_last", 32'h5008, 128'hE4_000000E3_000000E2_000000E1, 5);
    run_zero_wait("after_flush_last", 32'h500C, 128'hF4_000000F3_000000F2_000000F1, 0);

    // Timeout: beats 0 and 1 return, then silence; abort once the counter reaches 8.
    @(negedge clk);
    bus_if.ic_valid_req_i = 1'b1;
    bus_if.ic_addr_i      = 32'h3000;
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      bus_if.ic_valid_req_i = 1'b0;
      check($sformatf("tmo c%0d ready", k), bus_if.ic_ready_o, (k == 13));
      check($sformatf("tmo c%0d err", k),   bus_if.ic_err_o,   (k == 13));
      if (k == 15) check("tmo c15 req", bus_if.mem_req_o, 1'b0);
      bus_if.mem_gnt_i    = (k <= 4);
      bus_if.mem_rvalid_i = (k == 2 || k == 3 || k == 14);
      bus_if.mem_rdata_i  = 32'h0000_3000 + 32'(k);
      @(posedge clk);
    end
    @(negedge clk);
    idle_inputs();
    run_zero_wait("after_tmo", 32'h3000, 128'h34_00000033_00000032_00000031, 0);

    // Asynchronous reset in the middle of a refill.
    @(negedge clk);
    bus_if.ic_valid_req_i = 1'b1;
    bus_if.ic_addr_i      = 32'h4000;
    @(posedge clk);
    @(negedge clk);
    bus_if.ic_valid_req_i = 1'b0;
    check("rst pre req", bus_if.mem_req_o, 1'b1);
    bus_if.mem_gnt_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst async req",   bus_if.mem_req_o,  1'b0);
    check("rst async ready", bus_if.ic_ready_o, 1'b0);
    check("rst async err",   bus_if.ic_err_o,   1'b0);
    check("rst async addr",  bus_if.mem_addr_o, 32'h0);
    check("rst async data",  bus_if.ic_data_o,  128'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    bus_if.mem_rvalid_i = 1'b1;
    bus_if.mem_rdata_i  = 32'hBAD0;
    @(posedge clk);
    @(negedge clk);
    check("rst stray req",   bus_if.mem_req_o,  1'b0);
    check("rst stray ready", bus_if.ic_ready_o, 1'b0);
    idle_inputs();
    run_zero_wait("after_rst", 32'h4000, 128'h44_00000043_00000042_00000041, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
